servo_pwm_bank: RTL and testbench
=================================

Name: servo_pwm_bank

Overview:
Parametrised multi-channel servo pulse generator, successor to the fixed 3-phase servo transmitter.
- Each frame is HEAD (always high), VALUE (high while count < channel value), then a programmable low TAIL.
- Channel values are written into staging registers and copied to shadow registers only at frame start, so pulses never glitch mid-frame.
- Adds per-channel enable, a tick prescaler, a frame-start strobe, and an optional slew limiter. Sits between the control register bus and the servo output pins.

Parameters:
RESOLUTION, 8, width of channel values and of the HEAD/VALUE phase counter; each phase is 2^RESOLUTION ticks
CHANNELS, 4, number of servo outputs, 1..16
ADDR_WIDTH, 2, address width; must satisfy 2^ADDR_WIDTH >= CHANNELS
TAIL_LEN, 4608, TAIL phase length in ticks, >= 1
PRESCALE, 1, servoclk cycles per tick, >= 1
RAMP_STEP, 4, maximum shadow change per frame; used only with SERVO_RAMP_EN

Ports:
servoclk  in  1  sole clock; all logic is synchronous to it
rst  in  1  reset, asynchronous, active-high
we  in  1  write strobe, sampled on servoclk
addr  in  ADDR_WIDTH  channel select for the write
D  in  RESOLUTION  channel value written to staging[addr]
ch_en  in  CHANNELS  per-channel enable, sampled at frame start
servo  out  CHANNELS  registered PWM outputs
frame_start  out  1  one-cycle pulse on the servoclk cycle in which shadows load

Behaviour:
- Reset (asynchronous): staging, shadow and en_q clear to 0; servo clears to 0; frame_start clears to 0; prescaler clears to 0.
- Reset also sets state = TAIL and cnt = TAIL_LEN-1, so the first tick after release starts a frame.
- Tick: asserted when the prescaler equals PRESCALE-1; the prescaler then wraps to 0. With PRESCALE=1, every cycle is a tick.
- State machine (advances on ticks only):
  - HEAD: cnt counts 0..2^R-1, then goes to VALUE with cnt=0.
  - VALUE: cnt counts 0..2^R-1, then goes to TAIL with cnt=0.
  - TAIL: cnt counts 0..TAIL_LEN-1, then goes to HEAD with cnt=0.
  - Frame length = 2*2^R + TAIL_LEN ticks.
- Frame start is the TAIL->HEAD tick. On that tick: shadow[i] <= staging[i], en_q <= ch_en, and frame_start pulses for exactly that servoclk cycle.
- Output function, computed from pre-update state/cnt and registered every servoclk cycle (one-cycle lag; phase lengths stay exact):
  - servo[i] = en_q[i] & (HEAD | (VALUE & cnt < shadow[i])).
  - TAIL forces 0.
- Value boundaries: shadow=0 gives a pulse of exactly 2^R ticks. shadow=2^R-1 gives 2*2^R-1 ticks. The output is never high through a whole VALUE phase.
- Writes: a write with we=1 updates staging[addr] on the next servoclk edge, in any state.
  - Writes with addr >= CHANNELS are ignored.
  - The last write before the frame-start tick wins; a write on the same cycle as frame start is NOT loaded (shadow takes the old staging value).
- ch_en changes mid-frame have no effect until the next frame start. A channel disabled at frame start stays low for the whole frame.
- Reset mid-frame drops all outputs low immediately; staging contents are lost.
- Counter widths: cnt is wide enough for max(2^R, TAIL_LEN); compares are unsigned.

Optional Feature:
SERVO_RAMP_EN
- Defined: at frame start, shadow[i] moves toward staging[i] by at most RAMP_STEP, saturating exactly at the target with no overshoot and no wrap.
- Undefined: shadow[i] <= staging[i] directly, and RAMP_STEP is unused.

Decomposition:
- Package servo_pkg holds the state encoding (HEAD=2'b00, VALUE=2'b01, TAIL=2'b10) and a clog2 function for counter widths.
- One sub-module, servo_tick_gen: the PRESCALE counter producing the tick enable.
- The channel datapath (staging/shadow/output) stays in a generate loop inside servo_pwm_bank.

Test Plan:
Benches use RESOLUTION=4, CHANNELS=2, TAIL_LEN=8, PRESCALE=1, so the frame is 40 ticks.
- Reset release, no writes, ch_en=2'b11 -> frame_start on cycle 1; both servo high for 16 cycles, then low for 24; repeats every 40 cycles.
- Write ch0=5, ch1=15 during frame 1 -> frame 1 pulses are 16 cycles wide; from frame 2, ch0 is high 21 cycles and ch1 is high 31.
- Write to addr=3 -> no staging change; both channels' pulse widths are unchanged.
- ch_en=2'b01 raised mid-frame, then held -> ch1 is unaffected until the next frame_start, then stays low for the entire following frame.
- Assert rst during VALUE -> servo goes to 0 within the same cycle; after release the first frame_start occurs one tick later and the pulse width is 16.
- With PRESCALE=3 -> all phase lengths triple. With SERVO_RAMP_EN and RAMP_STEP=4, write 0->15 -> shadow takes 4, 8, 12, 15 on successive frames.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM bank: frame phase encoding and a width helper.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_HEAD  = 2'b00,
    ST_VALUE = 2'b01,
    ST_TAIL  = 2'b10
  } servo_state_e;

  // Bits needed to hold 0..v-1; never less than one.
  function automatic int clog2(input int v);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler: o_tick is high for one servoclk cycle out of every PRESCALE.
module servo_tick_gen
  import servo_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic servoclk,
  input  logic rst,
  output logic o_tick
);

  localparam int PW = clog2(PRESCALE);

  logic [PW-1:0] r_pre;

  assign o_tick = (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge servoclk or posedge rst) begin
    if (rst)         r_pre <= '0;
    else if (o_tick) r_pre <= '0;
    else             r_pre <= r_pre + PW'(1);
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo pulse generator; staged values reach the outputs only at frame start.
// Build with SERVO_RAMP_EN defined to limit each shadow change to RAMP_STEP per frame.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int CHANNELS   = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int TAIL_LEN   = 4608,
  parameter int PRESCALE   = 1,
  parameter int RAMP_STEP  = 4
) (
  input  logic                  servoclk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [RESOLUTION-1:0] D,
  input  logic [CHANNELS-1:0]   ch_en,
  output logic [CHANNELS-1:0]   servo,
  output logic                  frame_start
);

  localparam int PHASE = 2 ** RESOLUTION;
  localparam int CW    = clog2((PHASE > TAIL_LEN) ? PHASE : TAIL_LEN);

  logic                w_tick;
  logic                w_frame_tick;
  logic                w_in_head;
  logic                w_in_value;
  servo_state_e        r_state;
  servo_state_e        w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CHANNELS-1:0] r_en_q;
  logic [CHANNELS-1:0] r_servo;
  logic [CHANNELS-1:0] w_servo_nxt;
  logic                r_frame_start;

  servo_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .servoclk (servoclk),
    .rst      (rst),
    .o_tick   (w_tick)
  );

  // Reset parks at the last TAIL count so the first tick opens a frame.
  always_ff @(posedge servoclk or posedge rst) begin
    if (rst) begin
      r_state <= ST_TAIL;
      r_cnt   <= CW'(TAIL_LEN - 1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_frame_tick = 1'b0;
    if (w_tick) begin
      w_cnt_nxt = r_cnt + CW'(1);
      case (r_state)
        ST_HEAD: if (r_cnt == CW'(PHASE - 1)) begin
          w_state_nxt = ST_VALUE;
          w_cnt_nxt   = '0;
        end
        ST_VALUE: if (r_cnt == CW'(PHASE - 1)) begin
          w_state_nxt = ST_TAIL;
          w_cnt_nxt   = '0;
        end
        ST_TAIL: if (r_cnt == CW'(TAIL_LEN - 1)) begin
          w_state_nxt  = ST_HEAD;
          w_cnt_nxt    = '0;
          w_frame_tick = 1'b1;
        end
        default: begin
          w_state_nxt = ST_TAIL;
          w_cnt_nxt   = CW'(TAIL_LEN - 1);
        end
      endcase
    end
  end

  always_comb begin
    w_in_head  = (r_state == ST_HEAD);
    w_in_value = (r_state == ST_VALUE);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [RESOLUTION-1:0] r_staging;
    logic [RESOLUTION-1:0] r_shadow;
    logic [RESOLUTION-1:0] w_load;

`ifdef SERVO_RAMP_EN
    localparam logic [RESOLUTION:0] STEP = (RESOLUTION + 1)'(RAMP_STEP);
    logic [RESOLUTION:0] w_up;
    logic [RESOLUTION:0] w_dn;

    assign w_up = {1'b0, r_staging} - {1'b0, r_shadow};
    assign w_dn = {1'b0, r_shadow} - {1'b0, r_staging};

    // Step toward the target, landing exactly on it once within reach.
    always_comb begin
      w_load = r_staging;
      if ((r_staging > r_shadow) && (w_up > STEP))
        w_load = r_shadow + STEP[RESOLUTION-1:0];
      else if ((r_shadow > r_staging) && (w_dn > STEP))
        w_load = r_shadow - STEP[RESOLUTION-1:0];
    end
`else
    assign w_load = r_staging;
`endif

    // Shadow samples staging before this edge's write, so a same-cycle write waits a frame.
    always_ff @(posedge servoclk or posedge rst) begin
      if (rst) begin
        r_staging <= '0;
        r_shadow  <= '0;
      end else begin
        if (w_frame_tick) r_shadow <= w_load;
        if (we && (int'(addr) == i)) r_staging <= D;
      end
    end

    assign w_servo_nxt[i] = r_en_q[i] &
                            (w_in_head | (w_in_value & (r_cnt < CW'(r_shadow))));
  end

  always_ff @(posedge servoclk or posedge rst) begin
    if (rst) begin
      r_en_q        <= '0;
      r_servo       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_frame_tick) r_en_q <= ch_en;
      r_servo       <= w_servo_nxt;
      r_frame_start <= w_frame_tick;
    end
  end

  assign servo       = r_servo;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Scoreboard bench for servo_pwm_bank: frame-position model predicts per-frame pulse widths.
// A second instance with PRESCALE=3 checks tripled phase lengths.
module tb_servo_pwm_bank;

  localparam int R     = 4;
  localparam int CH    = 2;
  localparam int AW    = 2;
  localparam int TL    = 8;
  localparam int PHASE = 1 << R;
  localparam int FRAME = 2 * PHASE + TL;
  localparam int RSTEP = 4;

  logic          servoclk;
  logic          rst = 1'b1;
  logic          we;
  logic [AW-1:0] addr;
  logic [R-1:0]  D;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] servo;
  logic          frame_start;

  logic          we1;
  logic [AW-1:0] addr1;
  logic [R-1:0]  d1;
  logic [CH-1:0] en1;
  logic [CH-1:0] servo1;
  logic          fs1;

  int n_vec = 0;
  int n_err = 0;

  servo_pwm_bank #(
    .RESOLUTION(R), .CHANNELS(CH), .ADDR_WIDTH(AW), .TAIL_LEN(TL), .PRESCALE(1), .RAMP_STEP(RSTEP)
  ) dut (
    .servoclk(servoclk), .rst(rst), .we(we), .addr(addr), .D(D), .ch_en(ch_en),
    .servo(servo), .frame_start(frame_start)
  );

  servo_pwm_bank #(
    .RESOLUTION(R), .CHANNELS(CH), .ADDR_WIDTH(AW), .TAIL_LEN(TL), .PRESCALE(3), .RAMP_STEP(RSTEP)
  ) dut_ps3 (
    .servoclk(servoclk), .rst(rst), .we(we1), .addr(addr1), .D(d1), .ch_en(en1),
    .servo(servo1), .frame_start(fs1)
  );

  initial begin
    servoclk = 1'b0;
    forever #5 servoclk = ~servoclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, n_vec=%0d", n_vec);
    $fatal(1);
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int w0;
    int w1;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          m_e;
  exp_t          mon_e;
  int            m_pos = FRAME - 1;
  bit            m_fs  = 1'b0;
  int            m_stg[CH];
  int            m_sh[CH];
  logic [CH-1:0] m_en = '0;

  function automatic int next_sh(input int sh, input int stg);
`ifdef SERVO_RAMP_EN
    if (stg > sh + RSTEP) return sh + RSTEP;
    if (stg < sh - RSTEP) return sh - RSTEP;
    return stg;
`else
    if (sh < 0) return stg;
    return stg;
`endif
  endfunction

  always @(posedge servoclk or posedge rst) begin
    if (rst) begin
      m_pos = FRAME - 1;
      m_fs  = 1'b0;
      m_en  = '0;
      for (int c = 0; c < CH; c++) begin
        m_stg[c] = 0;
        m_sh[c]  = 0;
      end
      exp_q.delete();
    end else begin
      m_fs = 1'b0;
      if (m_pos == FRAME - 1) begin
        m_pos = 0;
        m_fs  = 1'b1;
        for (int c = 0; c < CH; c++) m_sh[c] = next_sh(m_sh[c], m_stg[c]);
        m_en   = ch_en;
        m_e.w0 = m_en[0] ? PHASE + m_sh[0] : 0;
        m_e.w1 = m_en[1] ? PHASE + m_sh[1] : 0;
        exp_q.push_back(m_e);
      end else begin
        m_pos++;
      end
      if (we && (int'(addr) < CH)) m_stg[int'(addr)] = int'(D);
    end
  end

  // ---------------- monitors ----------------
  bit in_frame = 1'b0;
  int cnt0, cnt1, flen;

  always @(negedge servoclk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      chk("frame_start", int'(frame_start), int'(m_fs));
      if (frame_start) begin
        if (in_frame) begin
          if (exp_q.size() < 2) begin
            chk("queue_depth", exp_q.size(), 2);
          end else begin
            mon_e = exp_q.pop_front();
            chk("width_ch0", cnt0, mon_e.w0);
            chk("width_ch1", cnt1, mon_e.w1);
            chk("frame_len", flen, FRAME);
          end
        end
        in_frame = 1'b1;
        cnt0 = 0;
        cnt1 = 0;
        flen = 0;
      end
      if (in_frame) begin
        cnt0 += int'(servo[0]);
        cnt1 += int'(servo[1]);
        flen++;
      end
    end
  end

  bit in1 = 1'b0;
  int c10, c11, len1;

  always @(negedge servoclk) begin
    if (rst) begin
      in1 = 1'b0;
    end else begin
      if (fs1) begin
        if (in1) begin
          chk("ps3_frame_len", len1, 3 * FRAME);
          chk("ps3_width_ch0", c10, 3 * PHASE);
          chk("ps3_width_ch1", c11, 3 * PHASE);
        end
        in1  = 1'b1;
        c10  = 0;
        c11  = 0;
        len1 = 0;
      end
      if (in1) begin
        c10 += int'(servo1[0]);
        c11 += int'(servo1[1]);
        len1++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_pos(input int p);
    int n;
    n = 0;
    @(negedge servoclk);
    while (m_pos != p && n < 200) begin
      @(negedge servoclk);
      n++;
    end
    if (m_pos != p) chk("wait_pos_timeout", m_pos, p);
  endtask

  task automatic do_write(input int a, input int d);
    we   = 1'b1;
    addr = AW'(a);
    D    = R'(d);
    @(negedge servoclk);
    we   = 1'b0;
  endtask

  int exp_hi;

  initial begin
    we    = 1'b0;
    addr  = '0;
    D     = '0;
    ch_en = 2'b11;
    we1   = 1'b0;
    addr1 = '0;
    d1    = '0;
    en1   = 2'b11;

    repeat (3) @(negedge servoclk);
    chk("reset_servo", int'(servo), 0);
    chk("reset_frame_start", int'(frame_start), 0);
    chk("reset_servo_ps3", int'(servo1), 0);
    rst = 1'b0;
    repeat (2 * FRAME) @(negedge servoclk);

    // new values mid-frame: current frame unchanged, then 21 and 31
    wait_pos(5);
    do_write(0, 5);
    do_write(1, 15);
    repeat (3 * FRAME) @(negedge servoclk);

    // out-of-range addresses leave staging alone
    wait_pos(8);
    do_write(3, 9);
    do_write(2, 1);
    repeat (2 * FRAME) @(negedge servoclk);

    // last write before frame start wins; a write on the start cycle waits a frame
    wait_pos(20);
    do_write(0, 9);
    wait_pos(FRAME - 2);
    do_write(0, 7);
    do_write(0, 2);
    repeat (3 * FRAME) @(negedge servoclk);

    // enable change mid-frame applies only from the next frame start
    wait_pos(10);
    ch_en = 2'b01;
    repeat (3 * FRAME) @(negedge servoclk);
    ch_en = 2'b11;

    // large swings exercise the ramp path when it is built in
    wait_pos(3);
    do_write(0, 5);
    do_write(1, 0);
    repeat (5 * FRAME) @(negedge servoclk);
    wait_pos(3);
    do_write(1, 15);
    repeat (5 * FRAME) @(negedge servoclk);

    // asynchronous reset while ch0 is high in VALUE
    wait_pos(18);
    exp_hi = (m_en[0] && (m_sh[0] > 1)) ? 1 : 0;
    chk("pre_reset_servo0", int'(servo[0]), exp_hi);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_servo", int'(servo), 0);
    chk("async_reset_servo_ps3", int'(servo1), 0);
    repeat (2) @(negedge servoclk);
    rst = 1'b0;
    repeat (4 * FRAME) @(negedge servoclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
